// File: rtl/core_bus_arbiter_if.sv
// Cache-bus request/response types and the arbiter's port bundle.
// The master modport is the requester/bridge side; the slave modport is the arbiter side.
package core_bus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [1:0]  burst_size;
        logic        cached;
        logic [1:0]  data_size;
        logic [31:0] addr;
        logic        data_ok;
        logic        data_last;
        logic [3:0]  data_strobe;
        logic [31:0] w_data;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;
endpackage

interface core_bus_arbiter_if #(
    parameter int REQ_CNT = 2
);
    core_bus_pkg::cache_bus_req_t  [REQ_CNT-1:0] req_i;
    core_bus_pkg::cache_bus_resp_t [REQ_CNT-1:0] resp_o;
    logic                          [REQ_CNT-1:0] busy_o;
    core_bus_pkg::cache_bus_req_t                bus_req_o;
    core_bus_pkg::cache_bus_resp_t               bus_resp_i;
    logic                                        owner_o;

    modport master (
        output req_i,
        output bus_resp_i,
        input  resp_o,
        input  busy_o,
        input  bus_req_o,
        input  owner_o
    );

    modport slave (
        input  req_i,
        input  bus_resp_i,
        output resp_o,
        output busy_o,
        output bus_req_o,
        output owner_o
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// Two-port cache-bus arbiter: grants a whole transaction (address phase plus data beats)
// to one requester; port 1 is preferred until port 0 has lost MAX_LOSS arbitrations in a row.
module core_bus_arbiter #(
    parameter int REQ_CNT  = 2,
    parameter int MAX_LOSS = 4
) (
    input logic               clk,
    input logic               rst_n,
    core_bus_arbiter_if.slave bus
);
    import core_bus_pkg::*;

    localparam int LOSS_W = $clog2(MAX_LOSS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_reg;
    logic              owner_reg;
    logic [LOSS_W-1:0] loss_reg;

    logic [REQ_CNT-1:0] req_valid;
    logic               both_valid;
    logic               loss_hit;
    logic               winner;
    logic               in_addr;
    logic               in_data;
    cache_bus_req_t     owner_req;
    cache_bus_req_t     bus_req_next;
    cache_bus_resp_t    addr_resp;
    cache_bus_resp_t    data_resp;

    generate
        for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_valid
            assign req_valid[gi] = bus.req_i[gi].valid;
        end
    endgenerate

    assign both_valid = &req_valid;
    assign loss_hit   = (loss_reg >= LOSS_W'(MAX_LOSS));
    // Port 1 wins by default; port 0 only takes a contested round once starved.
    assign winner     = req_valid[1] & ~(req_valid[0] & loss_hit);
    assign owner_req  = bus.req_i[owner_reg];

    // Outputs are gated by rst_n so everything reads idle while reset is held.
    assign in_addr = rst_n && (state_reg == ADDR);
    assign in_data = rst_n && (state_reg == DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b1;
            loss_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        owner_reg <= winner;
                        state_reg <= ADDR;
                        if (!winner) begin
                            loss_reg <= '0;
                        end else if (both_valid && (loss_reg < LOSS_W'(MAX_LOSS))) begin
                            loss_reg <= loss_reg + LOSS_W'(1);
                        end
                    end
                end
                ADDR: begin
                    if (!owner_req.valid) begin
                        state_reg <= IDLE;
                    end else if (bus.bus_resp_i.ready) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (bus.bus_resp_i.data_ok && bus.bus_resp_i.data_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_req_next = '0;
        if (in_addr) begin
            bus_req_next = owner_req;
        end else if (in_data) begin
            bus_req_next       = owner_req;
            bus_req_next.valid = 1'b0;
        end
    end

    always_comb begin
        addr_resp       = '0;
        addr_resp.ready = bus.bus_resp_i.ready;
        data_resp       = bus.bus_resp_i;
        data_resp.ready = 1'b0;
    end

    assign bus.bus_req_o = bus_req_next;
    assign bus.owner_o   = owner_reg;

    generate
        for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_port
            logic is_owner;
            assign is_owner        = (owner_reg == 1'(gi));
            assign bus.resp_o[gi]  = !is_owner ? '0 :
                                     in_addr   ? addr_resp :
                                     in_data   ? data_resp : '0;
            assign bus.busy_o[gi]  = (in_addr || in_data) && !is_owner;
        end
    endgenerate
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_core_bus_arbiter;
    import core_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_bus_arbiter_if #(.REQ_CNT(2)) bif ();

    core_bus_arbiter #(.REQ_CNT(2), .MAX_LOSS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One contested round: IDLE with both ports valid, ADDR with ready, single-beat DATA.
    task automatic arb_round(input logic exp_owner, input string tag);
        tick;
        bif.req_i[0]       = '0;
        bif.req_i[0].valid = 1'b1;
        bif.req_i[0].addr  = 32'h0000_0300;
        bif.req_i[1]       = '0;
        bif.req_i[1].valid = 1'b1;
        bif.req_i[1].addr  = 32'h0000_0400;
        bif.bus_resp_i     = '0;
        #1;
        chk({tag, " idle busy"}, 64'(bif.busy_o), 64'd0);
        tick;
        bif.bus_resp_i.ready = 1'b1;
        #1;
        chk({tag, " owner"}, 64'(bif.owner_o), 64'(exp_owner));
        chk({tag, " busy"}, 64'(bif.busy_o), exp_owner ? 64'd1 : 64'd2);
        chk({tag, " addr"}, 64'(bif.bus_req_o.addr), exp_owner ? 64'h400 : 64'h300);
        chk({tag, " ready"}, 64'(bif.resp_o[exp_owner].ready), 64'd1);
        tick;
        bif.bus_resp_i.ready     = 1'b0;
        bif.bus_resp_i.data_ok   = 1'b1;
        bif.bus_resp_i.data_last = 1'b1;
        bif.bus_resp_i.r_data    = 32'h0000_5A5A;
        #1;
        chk({tag, " data_ok"}, 64'(bif.resp_o[exp_owner].data_ok), 64'd1);
        chk({tag, " loser resp"}, 64'(bif.resp_o[!exp_owner]), 64'd0);
    endtask

    initial begin
        bif.req_i      = '0;
        bif.bus_resp_i = '0;
        rst_n          = 1'b0;
        tick;
        tick;
        #1;
        chk("reset owner", 64'(bif.owner_o), 64'd1);
        chk("reset busy", 64'(bif.busy_o), 64'd0);
        chk("reset bus_req", 64'(|bif.bus_req_o), 64'd0);
        rst_n = 1'b1;

        // Port 0 alone: cached 4-beat read, ready in the third cycle after the request.
        tick;
        bif.req_i[0].valid      = 1'b1;
        bif.req_i[0].cached     = 1'b1;
        bif.req_i[0].burst_size = 2'd3;
        bif.req_i[0].data_size  = 2'd2;
        bif.req_i[0].addr       = 32'h1C00_0010;
        #1;
        chk("s1 idle valid", 64'(bif.bus_req_o.valid), 64'd0);
        chk("s1 idle busy", 64'(bif.busy_o), 64'd0);
        tick;
        #1;
        chk("s1 addr owner", 64'(bif.owner_o), 64'd0);
        chk("s1 addr busy", 64'(bif.busy_o), 64'd2);
        chk("s1 addr valid", 64'(bif.bus_req_o.valid), 64'd1);
        chk("s1 addr addr", 64'(bif.bus_req_o.addr), 64'h1C00_0010);
        chk("s1 addr noready", 64'(bif.resp_o[0].ready), 64'd0);
        tick;
        bif.bus_resp_i.ready = 1'b1;
        #1;
        chk("s1 ready fwd", 64'(bif.resp_o[0].ready), 64'd1);
        chk("s1 resp1 zero", 64'(bif.resp_o[1]), 64'd0);
        for (int b = 0; b < 4; b++) begin
            tick;
            bif.req_i[0].valid       = 1'b0;
            bif.bus_resp_i.data_ok   = 1'b1;
            bif.bus_resp_i.data_last = (b == 3);
            bif.bus_resp_i.r_data    = 32'hA0 + 32'(b);
            #1;
            chk("s1 beat data_ok", 64'(bif.resp_o[0].data_ok), 64'd1);
            chk("s1 beat last", 64'(bif.resp_o[0].data_last), 64'(b == 3));
            chk("s1 beat r_data", 64'(bif.resp_o[0].r_data), 64'hA0 + 64'(b));
            chk("s1 beat ready masked", 64'(bif.resp_o[0].ready), 64'd0);
            chk("s1 beat valid", 64'(bif.bus_req_o.valid), 64'd0);
            chk("s1 beat busy", 64'(bif.busy_o), 64'd2);
        end
        tick;
        #1;
        chk("s1 end busy", 64'(bif.busy_o), 64'd0);
        chk("s1 end resp0", 64'(bif.resp_o[0]), 64'd0);
        chk("s1 end bus_req", 64'(|bif.bus_req_o), 64'd0);

        // Simultaneous requests: port 1 (write) first, port 0 after one idle cycle.
        tick;
        bif.bus_resp_i           = '0;
        bif.req_i[0]             = '0;
        bif.req_i[0].valid       = 1'b1;
        bif.req_i[0].addr        = 32'h0000_0100;
        bif.req_i[1]             = '0;
        bif.req_i[1].valid       = 1'b1;
        bif.req_i[1].write       = 1'b1;
        bif.req_i[1].addr        = 32'h0000_2000;
        bif.req_i[1].data_strobe = 4'hF;
        bif.req_i[1].w_data      = 32'h0000_55AA;
        #1;
        chk("s2 idle busy", 64'(bif.busy_o), 64'd0);
        tick;
        bif.bus_resp_i.ready = 1'b1;
        #1;
        chk("s2 owner", 64'(bif.owner_o), 64'd1);
        chk("s2 busy", 64'(bif.busy_o), 64'd1);
        chk("s2 addr", 64'(bif.bus_req_o.addr), 64'h2000);
        chk("s2 write", 64'(bif.bus_req_o.write), 64'd1);
        chk("s2 ready1", 64'(bif.resp_o[1].ready), 64'd1);
        chk("s2 resp0 addr", 64'(bif.resp_o[0]), 64'd0);
        tick;
        bif.bus_resp_i.ready     = 1'b0;
        bif.req_i[1].data_ok     = 1'b1;
        bif.req_i[1].data_last   = 1'b1;
        bif.bus_resp_i.data_ok   = 1'b1;
        bif.bus_resp_i.data_last = 1'b1;
        #1;
        chk("s2 w_data", 64'(bif.bus_req_o.w_data), 64'h55AA);
        chk("s2 wr data_ok", 64'(bif.bus_req_o.data_ok), 64'd1);
        chk("s2 strobe", 64'(bif.bus_req_o.data_strobe), 64'hF);
        chk("s2 resp1 data_ok", 64'(bif.resp_o[1].data_ok), 64'd1);
        chk("s2 resp0 data", 64'(bif.resp_o[0]), 64'd0);
        chk("s2 busy data", 64'(bif.busy_o), 64'd1);
        tick;
        bif.req_i[1]   = '0;
        bif.bus_resp_i = '0;
        #1;
        chk("s2 gap busy", 64'(bif.busy_o), 64'd0);
        tick;
        bif.bus_resp_i.ready = 1'b1;
        #1;
        chk("s2 p0 owner", 64'(bif.owner_o), 64'd0);
        chk("s2 p0 addr", 64'(bif.bus_req_o.addr), 64'h100);
        tick;
        bif.req_i[0].valid       = 1'b0;
        bif.bus_resp_i.ready     = 1'b0;
        bif.bus_resp_i.data_ok   = 1'b1;
        bif.bus_resp_i.data_last = 1'b1;
        bif.bus_resp_i.r_data    = 32'h0000_1234;
        #1;
        chk("s2 p0 r_data", 64'(bif.resp_o[0].r_data), 64'h1234);
        tick;
        bif.bus_resp_i = '0;
        #1;
        chk("s2 end busy", 64'(bif.busy_o), 64'd0);

        // Starvation guard: four port-1 wins, then port 0, then port 1 again.
        arb_round(1'b1, "s3 r1");
        arb_round(1'b1, "s3 r2");
        arb_round(1'b1, "s3 r3");
        arb_round(1'b1, "s3 r4");
        arb_round(1'b0, "s3 r5");
        arb_round(1'b1, "s3 r6");

        // Port 0 uncached single-beat read.
        tick;
        bif.req_i[1]            = '0;
        bif.req_i[0]            = '0;
        bif.req_i[0].valid      = 1'b1;
        bif.req_i[0].data_size  = 2'd2;
        bif.req_i[0].addr       = 32'h1FD0_0004;
        bif.bus_resp_i          = '0;
        #1;
        chk("s4 idle busy", 64'(bif.busy_o), 64'd0);
        tick;
        bif.bus_resp_i.ready = 1'b1;
        #1;
        chk("s4 owner", 64'(bif.owner_o), 64'd0);
        chk("s4 addr", 64'(bif.bus_req_o.addr), 64'h1FD0_0004);
        chk("s4 cached", 64'(bif.bus_req_o.cached), 64'd0);
        tick;
        bif.req_i[0].valid       = 1'b0;
        bif.bus_resp_i.ready     = 1'b0;
        bif.bus_resp_i.data_ok   = 1'b1;
        bif.bus_resp_i.data_last = 1'b1;
        bif.bus_resp_i.r_data    = 32'hDEAD_BEEF;
        #1;
        chk("s4 r_data", 64'(bif.resp_o[0].r_data), 64'hDEAD_BEEF);
        chk("s4 last", 64'(bif.resp_o[0].data_last), 64'd1);
        tick;
        bif.bus_resp_i = '0;
        #1;
        chk("s4 end busy", 64'(bif.busy_o), 64'd0);
        chk("s4 end resp0", 64'(bif.resp_o[0]), 64'd0);

        // Port 0 withdraws in ADDR; waiting port 1 is granted next.
        tick;
        bif.req_i[0].valid = 1'b1;
        bif.req_i[0].addr  = 32'h0000_0600;
        tick;
        #1;
        chk("s6 owner0", 64'(bif.owner_o), 64'd0);
        chk("s6 valid0", 64'(bif.bus_req_o.valid), 64'd1);
        bif.req_i[0].valid = 1'b0;
        bif.req_i[1]       = '0;
        bif.req_i[1].valid = 1'b1;
        bif.req_i[1].addr  = 32'h0000_0700;
        #1;
        chk("s6 withdrawn valid", 64'(bif.bus_req_o.valid), 64'd0);
        tick;
        #1;
        chk("s6 idle busy", 64'(bif.busy_o), 64'd0);
        chk("s6 idle valid", 64'(bif.bus_req_o.valid), 64'd0);
        tick;
        bif.bus_resp_i.ready = 1'b1;
        #1;
        chk("s6 owner1", 64'(bif.owner_o), 64'd1);
        chk("s6 addr1", 64'(bif.bus_req_o.addr), 64'h700);
        tick;
        bif.req_i[1].valid       = 1'b0;
        bif.bus_resp_i.ready     = 1'b0;
        bif.bus_resp_i.data_ok   = 1'b1;
        bif.bus_resp_i.data_last = 1'b1;
        tick;
        bif.bus_resp_i = '0;

        // Reset during beat 2 of a port-1 burst.
        tick;
        bif.req_i[1].valid      = 1'b1;
        bif.req_i[1].burst_size = 2'd3;
        bif.req_i[1].addr       = 32'h0000_0800;
        tick;
        bif.bus_resp_i.ready = 1'b1;
        tick;
        bif.req_i[1].valid     = 1'b0;
        bif.bus_resp_i.ready   = 1'b0;
        bif.bus_resp_i.data_ok = 1'b1;
        #1;
        chk("s5 beat1", 64'(bif.resp_o[1].data_ok), 64'd1);
        tick;
        rst_n = 1'b0;
        #1;
        chk("s5 in reset busy", 64'(bif.busy_o), 64'd0);
        chk("s5 in reset resp1", 64'(bif.resp_o[1]), 64'd0);
        chk("s5 in reset bus_req", 64'(|bif.bus_req_o), 64'd0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("s5 after busy", 64'(bif.busy_o), 64'd0);
        chk("s5 after valid", 64'(bif.bus_req_o.valid), 64'd0);
        chk("s5 after owner", 64'(bif.owner_o), 64'd1);
        chk("s5 after resp1", 64'(bif.resp_o[1]), 64'd0);
        tick;
        bif.bus_resp_i = '0;

        // Reset clears the owner and the loss counter.
        tick;
        bif.req_i[0].valid = 1'b1;
        tick;
        #1;
        chk("s7 owner0", 64'(bif.owner_o), 64'd0);
        rst_n = 1'b1;
        tick;
        rst_n        = 1'b0;
        bif.req_i[0] = '0;
        tick;
        rst_n = 1'b1;
        #1;
        chk("s7 reset owner", 64'(bif.owner_o), 64'd1);
        arb_round(1'b1, "s7 r1");
        arb_round(1'b1, "s7 r2");
        arb_round(1'b1, "s7 r3");
        arb_round(1'b1, "s7 r4");
        tick;
        rst_n          = 1'b0;
        bif.req_i      = '0;
        bif.bus_resp_i = '0;
        tick;
        rst_n = 1'b1;
        arb_round(1'b1, "s7 post-reset");
        tick;
        bif.req_i      = '0;
        bif.bus_resp_i = '0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
